wavetable_fetch_sched: RTL and testbench
========================================

Name: wavetable_fetch_sched

Overview:
- Shares one 512x16 single-port wavetable RAM (synchronous read, one-cycle latency) between NVOICE voice phase accumulators and one host table-load write port.
- Arbitrates requests: writes win unless the last operation was a write; reads are round-robin.
- Sequences RAM control so the address, including the bank-select bit [8], is held stable while read data returns.
- Delivers the data word tagged with the requesting voice.

Parameters:
- NVOICE, 4, number of voice read requesters (2..8).
- VW, 2, width of voice index; must satisfy 2**VW >= NVOICE.

Ports:
- clk  in  1  system clock; all state on rising edge.
- rst  in  1  reset, asynchronous, active-high.
- req  in  NVOICE  per-voice read request level.
- req_addr  in  NVOICE*9  per-voice table address; voice i occupies bits [9i+8:9i].
- gnt  out  NVOICE  one-cycle pulse: voice i's address accepted.
- rd_data  out  16  fetched sample.
- rd_valid  out  1  one-cycle pulse: rd_data/rd_voice valid.
- rd_voice  out  VW  voice index owning rd_data.
- wr_req  in  1  host write request level.
- wr_addr  in  9  host write address.
- wr_data  in  16  host write data.
- wr_ack  out  1  one-cycle pulse: write performed.
- ram_addr  out  9  RAM address.
- ram_wdata  out  16  RAM write data.
- ram_rdata  in  16  RAM read data; valid the cycle after ram_re, and only while ram_addr[8] is unchanged.
- ram_ce  out  1  RAM enable.
- ram_we  out  1  RAM write enable.
- ram_re  out  1  RAM read enable.

Behaviour:
- States: IDLE, RD_ISSUE, RD_CAPT, WR. The state register is the only source of ram_ce/ram_we/ram_re.
- Reset:
  - state=IDLE; addr_q=0; wdata_q=0.
  - rr_ptr=NVOICE-1, so voice 0 has first priority.
  - last_wr=0; gnt=0; rd_valid=0; rd_data=0; rd_voice=0; wr_ack=0.
  - ram_ce=ram_we=ram_re=0; ram_addr=0; ram_wdata=0.
  - Reset mid-operation aborts the access: no gnt/rd_valid/wr_ack issued for it, and any RAM enable drops immediately.
- IDLE arbitration, one decision per IDLE cycle:
  - wr_req && (!last_wr || req==0) -> latch wr_addr/wr_data; go to WR.
  - else if any req -> select the first requesting voice searching rr_ptr+1, rr_ptr+2, ... modulo NVOICE. Latch its req_addr into addr_q and its index into vsel_q; rr_ptr<=index; go to RD_ISSUE.
  - else stay in IDLE with all RAM enables 0.
- WR (1 cycle):
  - ram_addr=addr_q, ram_wdata=wdata_q, ram_ce=ram_we=1.
  - wr_ack=1 in this cycle; last_wr<=1; go to IDLE.
- RD_ISSUE (1 cycle):
  - ram_addr=addr_q, ram_ce=ram_re=1.
  - gnt[vsel_q]=1 in this cycle only; last_wr<=0; go to RD_CAPT.
- RD_CAPT (1 cycle):
  - ram_addr=addr_q is held and ram_ce=ram_re=0.
  - At the clock edge: rd_data<=ram_rdata, rd_voice<=vsel_q, rd_valid<=1 (valid the following cycle only); go to IDLE.
- Timing:
  - Idle-bus read latency: req seen in cycle 0 -> gnt in cycle 1 -> rd_valid in cycle 3.
  - Sustained throughput: one access per 3 cycles (reads), 2 cycles (writes).
- ram_addr changes only on entry to WR or RD_ISSUE. ram_we and ram_re are never both 1.
- Requester rules:
  - Hold req_addr stable while req=1 and until gnt is seen.
  - req may stay high for back-to-back fetches; each gnt corresponds to exactly one rd_valid.
  - A req dropped before gnt is simply not served.
- Host rules: hold wr_addr/wr_data/wr_req until wr_ack. A persistent wr_req alternates with pending reads, so neither side starves.
- req_addr bits of non-selected voices are ignored. Simultaneous req on all voices are served in rotation 0,1,..,NVOICE-1.

Test Plan:
- Reset check: assert rst asynchronously mid RD_ISSUE -> ram_re=0 immediately, all outputs 0. After release with no requests, ram_ce stays 0 indefinitely.
- Write then read: host writes 0x1234 to 0x105 (wr_ack 1 cycle, ram_we=1 once). Voice 2 then requests 0x105 -> gnt[2] one cycle after req, rd_valid 3 cycles after req with rd_data=0x1234, rd_voice=2.
- Bank boundary: preload 0x0FF=0xAAAA and 0x100=0x5555. Voice 0 requests 0x0FF, then 0x100 back-to-back -> rd_data 0xAAAA then 0x5555. ram_addr is constant across each RD_ISSUE/RD_CAPT pair.
- Round-robin fairness: all four req held high for 12 accesses -> gnt order 0,1,2,3,0,1,2,3,0,1,2,3, with rd_voice matching. No two gnt bits are ever set together.
- Write/read contention: wr_req held high for 3 writes while voices 1 and 3 request -> order W, R1, W, R3, W. Three wr_acks and two rd_valids; no starvation.
- Dropped request: voice 1 raises req then drops it the cycle before arbitration while voice 0 is being served -> no gnt[1], no rd_valid with rd_voice=1.

Source files
------------

// File: rtl/wavetable_fetch_sched_if.sv
`default_nettype none
// ============================================================================
//  Module   : wavetable_fetch_sched_if
//  Brief    : Voice read-request and host table-load bus of the wavetable
//             fetch scheduler.
//  Revision : 1.0 - initial release
// ============================================================================
interface wavetable_fetch_sched_if #(
    parameter int NVOICE = 4,
    parameter int VW     = 2
) ();
    logic [NVOICE-1:0]   req;
    logic [NVOICE*9-1:0] req_addr;
    logic [NVOICE-1:0]   gnt;
    logic [15:0]         rd_data;
    logic                rd_valid;
    logic [VW-1:0]       rd_voice;
    logic                wr_req;
    logic [8:0]          wr_addr;
    logic [15:0]         wr_data;
    logic                wr_ack;

    // Requesters (voices + host) drive the master side.
    modport master (
        output req, req_addr, wr_req, wr_addr, wr_data,
        input  gnt, rd_data, rd_valid, rd_voice, wr_ack
    );

    modport slave (
        input  req, req_addr, wr_req, wr_addr, wr_data,
        output gnt, rd_data, rd_valid, rd_voice, wr_ack
    );
endinterface
`default_nettype wire

// File: rtl/wavetable_fetch_sched.sv
`default_nettype none
// ============================================================================
//  Module   : wavetable_fetch_sched
//  Brief    : Shares one 512x16 single-port wavetable RAM between NVOICE
//             round-robin voice readers and a host write port.
//  Revision : 1.0 - initial release
// ============================================================================
module wavetable_fetch_sched #(
    parameter int NVOICE = 4,
    parameter int VW     = 2
) (
    input  wire logic                   clk,
    input  wire logic                   rst,
    wavetable_fetch_sched_if.slave      bus,
    output logic [8:0]                  ram_addr,
    output logic [15:0]                 ram_wdata,
    input  wire logic [15:0]            ram_rdata,
    output logic                        ram_ce,
    output logic                        ram_we,
    output logic                        ram_re
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        RD_ISSUE = 2'd1,
        RD_CAPT  = 2'd2,
        WR       = 2'd3
    } state_t;

    state_t         state_q, state_d;
    logic [8:0]     addr_q, addr_d;
    logic [15:0]    wdata_q, wdata_d;
    logic [VW-1:0]  vsel_q, vsel_d;
    logic [VW-1:0]  rr_ptr_q, rr_ptr_d;
    logic           last_wr_q, last_wr_d;
    logic [15:0]    rd_data_q, rd_data_d;
    logic [VW-1:0]  rd_voice_q, rd_voice_d;
    logic           rd_valid_q, rd_valid_d;

    logic           w_pick_found;
    logic [VW-1:0]  w_pick_idx;
    logic [8:0]     w_pick_addr;

    // Round-robin search starting just after the last served voice.
    always_comb begin
        w_pick_found = 1'b0;
        w_pick_idx   = '0;
        for (int i = 1; i <= NVOICE; i++) begin
            if (!w_pick_found && bus.req[(int'(rr_ptr_q) + i) % NVOICE]) begin
                w_pick_found = 1'b1;
                w_pick_idx   = VW'((int'(rr_ptr_q) + i) % NVOICE);
            end
        end
    end

    assign w_pick_addr = bus.req_addr[9*int'(w_pick_idx) +: 9];

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        vsel_d     = vsel_q;
        rr_ptr_d   = rr_ptr_q;
        last_wr_d  = last_wr_q;
        rd_data_d  = rd_data_q;
        rd_voice_d = rd_voice_q;
        rd_valid_d = 1'b0;
        unique case (state_q)
            IDLE: begin
                // A write yields only to waiting reads right after another write.
                if (bus.wr_req && (!last_wr_q || bus.req == '0)) begin
                    addr_d  = bus.wr_addr;
                    wdata_d = bus.wr_data;
                    state_d = WR;
                end else if (w_pick_found) begin
                    addr_d   = w_pick_addr;
                    vsel_d   = w_pick_idx;
                    rr_ptr_d = w_pick_idx;
                    state_d  = RD_ISSUE;
                end
            end
            WR: begin
                last_wr_d = 1'b1;
                state_d   = IDLE;
            end
            RD_ISSUE: begin
                last_wr_d = 1'b0;
                state_d   = RD_CAPT;
            end
            RD_CAPT: begin
                rd_data_d  = ram_rdata;
                rd_voice_d = vsel_q;
                rd_valid_d = 1'b1;
                state_d    = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            addr_q     <= '0;
            wdata_q    <= '0;
            vsel_q     <= '0;
            rr_ptr_q   <= VW'(NVOICE - 1);
            last_wr_q  <= 1'b0;
            rd_data_q  <= '0;
            rd_voice_q <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            vsel_q     <= vsel_d;
            rr_ptr_q   <= rr_ptr_d;
            last_wr_q  <= last_wr_d;
            rd_data_q  <= rd_data_d;
            rd_voice_q <= rd_voice_d;
            rd_valid_q <= rd_valid_d;
        end
    end

    // RAM strobes decode straight from the state register, so an async
    // reset removes them without waiting for a clock edge.
    assign ram_addr  = addr_q;
    assign ram_wdata = wdata_q;
    assign ram_ce    = (state_q == WR) || (state_q == RD_ISSUE);
    assign ram_we    = (state_q == WR);
    assign ram_re    = (state_q == RD_ISSUE);

    always_comb begin
        bus.gnt = '0;
        if (state_q == RD_ISSUE) begin
            bus.gnt[vsel_q] = 1'b1;
        end
    end

    assign bus.wr_ack   = (state_q == WR);
    assign bus.rd_data  = rd_data_q;
    assign bus.rd_voice = rd_voice_q;
    assign bus.rd_valid = rd_valid_q;

endmodule
`default_nettype wire

// File: tb/tb_wavetable_fetch_sched.sv
`default_nettype none
// ============================================================================
//  Module   : tb_wavetable_fetch_sched
//  Brief    : Scoreboard bench for wavetable_fetch_sched with a RAM model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_wavetable_fetch_sched;

    localparam int NVOICE = 4;
    localparam int VW     = 2;
    localparam int EV_WR  = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [8:0]  ram_addr;
    logic [15:0] ram_wdata;
    logic [15:0] ram_rdata;
    logic        ram_ce, ram_we, ram_re;

    wavetable_fetch_sched_if #(.NVOICE(NVOICE), .VW(VW)) bus ();

    wavetable_fetch_sched #(.NVOICE(NVOICE), .VW(VW)) u_dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .ram_addr  (ram_addr),
        .ram_wdata (ram_wdata),
        .ram_rdata (ram_rdata),
        .ram_ce    (ram_ce),
        .ram_we    (ram_we),
        .ram_re    (ram_re)
    );

    always #5 clk = ~clk;

    // RAM model: data only valid while the bank bit matches the read address.
    logic [15:0] mem [512];
    logic [15:0] r_rdata;
    logic        r_bank;
    initial begin
        for (int i = 0; i < 512; i++) mem[i] = 16'h0;
        r_rdata = 16'h0;
        r_bank  = 1'b0;
    end
    always @(posedge clk) begin
        if (ram_ce && ram_we) mem[ram_addr] <= ram_wdata;
        if (ram_ce && ram_re) begin
            r_rdata <= mem[ram_addr];
            r_bank  <= ram_addr[8];
        end
    end
    assign ram_rdata = (ram_addr[8] == r_bank) ? r_rdata : 16'hDEAD;

    int n_cmp = 0;
    int n_err = 0;
    int n_we  = 0;
    int n_rv  = 0;
    int exp_evt [$];
    logic [17:0] exp_rd [$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Monitor: protocol invariants plus scoreboard pops.
    logic       prev_re = 1'b0;
    logic [8:0] prev_addr = '0;
    always @(negedge clk) begin
        int code;
        logic [17:0] e;
        if (rst) begin
            prev_re = 1'b0;
        end else begin
            chk("gnt_onehot", 32'($countones(bus.gnt) <= 1), 32'd1);
            chk("we_re_excl", 32'(ram_we & ram_re), 32'd0);
            if (prev_re) chk("addr_hold", 32'(ram_addr), 32'(prev_addr));
            prev_re   = ram_re;
            prev_addr = ram_addr;
            if (ram_we) n_we++;
            if (bus.gnt != '0 || bus.wr_ack) begin
                code = EV_WR;
                for (int i = 0; i < NVOICE; i++) if (bus.gnt[i]) code = i;
                if (exp_evt.size() == 0) chk("evt_extra", 32'(code), 32'd99);
                else chk("evt_order", 32'(code), 32'(exp_evt.pop_front()));
            end
            if (bus.rd_valid) begin
                n_rv++;
                if (exp_rd.size() == 0) begin
                    chk("rd_extra", {14'h0, bus.rd_voice, bus.rd_data}, 32'hFFFF_FFFF);
                end else begin
                    e = exp_rd.pop_front();
                    chk("rd_data", 32'(bus.rd_data), 32'(e[15:0]));
                    chk("rd_voice", 32'(bus.rd_voice), 32'(e[17:16]));
                end
            end
        end
    end

    task automatic host_write(input logic [8:0] a, input logic [15:0] d);
        logic seen = 1'b0;
        exp_evt.push_back(EV_WR);
        @(posedge clk); #1;
        bus.wr_req = 1'b1; bus.wr_addr = a; bus.wr_data = d;
        for (int k = 0; k < 20 && !seen; k++) begin
            @(negedge clk);
            if (bus.wr_ack) seen = 1'b1;
        end
        if (!seen) chk("wr_timeout", 32'd0, 32'd1);
        @(posedge clk); #1;
        bus.wr_req = 1'b0;
    endtask

    task automatic voice_read(input int v, input logic [8:0] a, input logic [15:0] d,
                              output int glat, output int rlat);
        glat = -1; rlat = -1;
        exp_evt.push_back(v);
        exp_rd.push_back({2'(v), d});
        @(posedge clk); #1;
        bus.req[v] = 1'b1;
        bus.req_addr[9*v +: 9] = a;
        for (int k = 0; k < 20 && rlat < 0; k++) begin
            @(negedge clk);
            if (bus.gnt[v] && glat < 0) glat = k;
            if (bus.rd_valid && bus.rd_voice == 2'(v)) rlat = k;
            if (rlat < 0) begin
                @(posedge clk); #1;
                if (glat >= 0) bus.req[v] = 1'b0;
            end
        end
        bus.req[v] = 1'b0;
        if (rlat < 0) chk("rd_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int glat, rlat, ng, nw, nr, we0, rv0;
        logic a_ack;
        logic [NVOICE-1:0] g;
        bus.req = '0; bus.req_addr = '0;
        bus.wr_req = 1'b0; bus.wr_addr = '0; bus.wr_data = '0;

        // Reset values.
        repeat (3) @(negedge clk);
        chk("rst_gnt", 32'(bus.gnt), 32'd0);
        chk("rst_rd_valid", 32'(bus.rd_valid), 32'd0);
        chk("rst_rd_data", 32'(bus.rd_data), 32'd0);
        chk("rst_rd_voice", 32'(bus.rd_voice), 32'd0);
        chk("rst_wr_ack", 32'(bus.wr_ack), 32'd0);
        chk("rst_ram_ctl", {29'h0, ram_ce, ram_we, ram_re}, 32'd0);
        chk("rst_ram_addr", 32'(ram_addr), 32'd0);
        chk("rst_ram_wdata", 32'(ram_wdata), 32'd0);
        @(posedge clk); #1 rst = 1'b0;

        // Async reset mid RD_ISSUE aborts the read.
        exp_evt.push_back(0);
        @(posedge clk); #1;
        bus.req[0] = 1'b1; bus.req_addr[8:0] = 9'h1FF;
        @(negedge clk);
        @(negedge clk);
        chk("issue_re", 32'(ram_re), 32'd1);
        #1 rst = 1'b1;
        #1;
        chk("arst_ram_ctl", {29'h0, ram_ce, ram_we, ram_re}, 32'd0);
        chk("arst_gnt", 32'(bus.gnt), 32'd0);
        chk("arst_ram_addr", 32'(ram_addr), 32'd0);
        chk("arst_outs", {bus.rd_valid, bus.wr_ack, 14'h0, bus.rd_data}, 32'd0);
        bus.req = '0;
        @(posedge clk); @(posedge clk); #1 rst = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            chk("idle_ce", 32'(ram_ce), 32'd0);
        end

        // Write then read with latency checks.
        we0 = n_we;
        host_write(9'h105, 16'h1234);
        chk("we_pulses", 32'(n_we - we0), 32'd1);
        repeat (2) @(posedge clk);
        voice_read(2, 9'h105, 16'h1234, glat, rlat);
        chk("gnt_latency", 32'(glat), 32'd1);
        chk("rd_latency", 32'(rlat), 32'd3);

        // Preloads for later phases.
        host_write(9'h0FF, 16'hAAAA);
        host_write(9'h100, 16'h5555);
        host_write(9'h020, 16'h2020);
        host_write(9'h030, 16'h3030);
        for (int v = 0; v < NVOICE; v++) host_write(9'(9'h010 + v), 16'(16'hC000 + v));

        // Bank boundary: back-to-back reads across address bit 8.
        exp_evt.push_back(0); exp_evt.push_back(0);
        exp_rd.push_back({2'd0, 16'hAAAA}); exp_rd.push_back({2'd0, 16'h5555});
        rv0 = n_rv; ng = 0;
        @(posedge clk); #1;
        bus.req[0] = 1'b1; bus.req_addr[8:0] = 9'h0FF;
        for (int k = 0; k < 40 && (n_rv - rv0) < 2; k++) begin
            @(negedge clk);
            g = bus.gnt;
            @(posedge clk); #1;
            if (g[0]) begin
                ng++;
                if (ng == 1) bus.req_addr[8:0] = 9'h100;
                else bus.req[0] = 1'b0;
            end
        end
        bus.req = '0;
        chk("bank_reads", 32'(n_rv - rv0), 32'd2);

        // Write/read contention: expected W, R1, W, R3, W.
        exp_evt.push_back(EV_WR); exp_evt.push_back(1); exp_evt.push_back(EV_WR);
        exp_evt.push_back(3); exp_evt.push_back(EV_WR);
        exp_rd.push_back({2'd1, 16'h2020}); exp_rd.push_back({2'd3, 16'h3030});
        nw = 0; nr = 0;
        @(posedge clk); #1;
        bus.wr_req = 1'b1; bus.wr_addr = 9'h040; bus.wr_data = 16'h4000;
        bus.req[1] = 1'b1; bus.req_addr[9 +: 9] = 9'h020;
        bus.req[3] = 1'b1; bus.req_addr[27 +: 9] = 9'h030;
        for (int k = 0; k < 60 && !(nw == 3 && nr == 2); k++) begin
            @(negedge clk);
            a_ack = bus.wr_ack; g = bus.gnt;
            if (bus.wr_ack) nw++;
            if (bus.rd_valid) nr++;
            @(posedge clk); #1;
            if (a_ack) begin
                if (nw == 3) bus.wr_req = 1'b0;
                else begin
                    bus.wr_addr = 9'(9'h040 + nw);
                    bus.wr_data = 16'(16'h4000 + nw);
                end
            end
            if (g[1]) bus.req[1] = 1'b0;
            if (g[3]) bus.req[3] = 1'b0;
        end
        bus.wr_req = 1'b0; bus.req = '0;
        chk("cont_wr_acks", 32'(nw), 32'd3);
        chk("cont_rd_valids", 32'(nr), 32'd2);
        repeat (4) @(posedge clk);

        // Round-robin: all voices request continuously for 12 accesses.
        for (int r = 0; r < 3; r++) begin
            for (int v = 0; v < NVOICE; v++) begin
                exp_evt.push_back(v);
                exp_rd.push_back({2'(v), 16'(16'hC000 + v)});
            end
        end
        rv0 = n_rv; ng = 0;
        @(posedge clk); #1;
        for (int v = 0; v < NVOICE; v++) bus.req_addr[9*v +: 9] = 9'(9'h010 + v);
        bus.req = '1;
        for (int k = 0; k < 100 && ng < 12; k++) begin
            @(negedge clk);
            if (bus.gnt != '0) ng++;
            if (ng == 12) begin
                @(posedge clk); #1;
                bus.req = '0;
            end
        end
        bus.req = '0;
        repeat (6) @(posedge clk);
        chk("rr_grants", 32'(ng), 32'd12);
        chk("rr_reads", 32'(n_rv - rv0), 32'd12);

        // Dropped request: voice 1 withdraws before arbitration.
        exp_evt.push_back(0);
        exp_rd.push_back({2'd0, 16'hC000});
        rv0 = n_rv;
        @(posedge clk); #1 bus.req[0] = 1'b1;
        @(posedge clk); #1 bus.req[1] = 1'b1;
        @(posedge clk); #1 bus.req[0] = 1'b0;
        @(posedge clk); #1 bus.req[1] = 1'b0;
        repeat (10) @(negedge clk);
        chk("drop_reads", 32'(n_rv - rv0), 32'd1);

        // Contention write data landed correctly.
        voice_read(2, 9'h041, 16'h4001, glat, rlat);
        voice_read(1, 9'h042, 16'h4002, glat, rlat);

        repeat (4) @(negedge clk);
        chk("evt_q_drain", 32'(exp_evt.size()), 32'd0);
        chk("rd_q_drain", 32'(exp_rd.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
